// File: rtl/data_latch_pkg.sv
// Shared constants and checker state for the data_latch primitive.
package data_latch_pkg;

   localparam int DATA_LATCH_DEF_WIDTH     = 2;
   localparam int DATA_LATCH_DEF_CNT_WIDTH = 16;

   // Widest data bus the checker can track. prev_out is kept at this fixed
   // width so the state struct does not depend on a module parameter.
   localparam int DATA_LATCH_MAX_WIDTH     = 64;

   // What the checker remembers from the previous clk edge.
   typedef struct packed {
      logic                            prev_valid;
      logic                            prev_enable;
      logic [DATA_LATCH_MAX_WIDTH-1:0] prev_out;
   } chk_state_t;

endpackage

// File: rtl/data_latch_checker.sv
// Clocked self-checker for data_latch. It samples enable/in/out on each
// rising clk edge and flags transparency or hold-stability violations.
// The error flag is sticky until reset and the count saturates.
module data_latch_checker
   import data_latch_pkg::*;
#(
   parameter int WIDTH     = DATA_LATCH_DEF_WIDTH,
   parameter int CNT_WIDTH = DATA_LATCH_DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     in,
   input  logic [WIDTH-1:0]     out,
   output logic                 err,
   output logic [CNT_WIDTH-1:0] err_cnt
);

   chk_state_t                       st_q, st_d;
   logic                             err_q, err_d;
   logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
   logic                             viol;
   logic [DATA_LATCH_MAX_WIDTH-1:0]  out_ext;

   assign out_ext = DATA_LATCH_MAX_WIDTH'(out);

   // Judge the current sample and compute the next checker state.
   always_comb begin
      viol = 1'b0;
      if (enable) begin
         viol = (out != in);
      end else if (st_q.prev_valid && !st_q.prev_enable) begin
         viol = (out_ext != st_q.prev_out);
      end

      st_d.prev_valid  = 1'b1;
      st_d.prev_enable = enable;
      st_d.prev_out    = out_ext;

      err_d = err_q | viol;
      cnt_d = cnt_q;
      if (viol && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Checker registers; reset clears history so the first edge has no stability check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

`ifndef SYNTHESIS
   // Report each violation in simulation as it is sampled.
   always_ff @(posedge clk) begin
      if (rst_n && viol) begin
         $error("data_latch violation at %0t: in=%0h out=%0h", $time, in, out);
      end
   end
`endif

   assign err     = err_q;
   assign err_cnt = cnt_q;

endmodule

// File: rtl/data_latch.sv
// Transparent, parameterised-width data latch with asynchronous active-low
// reset. clk only serves the optional checker, never the data path.
// Define DATA_LATCH_CHECKER_EN to build the clocked self-checker; otherwise
// chk_err and chk_err_cnt are tied to zero and the ports are unchanged.
module data_latch
   import data_latch_pkg::*;
#(
   parameter int                WIDTH       = DATA_LATCH_DEF_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
   parameter int                CNT_WIDTH   = DATA_LATCH_DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     in,
   output logic [WIDTH-1:0]     out,
   output logic                 chk_err,
   output logic [CNT_WIDTH-1:0] chk_err_cnt
);

   logic [WIDTH-1:0] latch_q;

   // Level-sensitive storage: reset overrides, enable makes it transparent.
   always_latch begin
      if (!rst_n) begin
         latch_q <= RESET_VALUE;
      end else if (enable) begin
         latch_q <= in;
      end
   end

   assign out = latch_q;

`ifdef DATA_LATCH_CHECKER_EN
   data_latch_checker #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_checker (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .in      (in),
      .out     (out),
      .err     (chk_err),
      .err_cnt (chk_err_cnt)
   );
`else
   logic unused_clk;
   assign unused_clk  = clk;
   assign chk_err     = 1'b0;
   assign chk_err_cnt = '0;
`endif

endmodule

// File: tb/tb_data_latch.sv
// Self-checking bench for data_latch: directed scenarios plus randomized
// stimulus compared against a behavioural model of the latch.
`timescale 1ns/1ps
module tb_data_latch;

   localparam int W  = 2;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic [W-1:0]  in;
   logic [W-1:0]  out;
   logic          chk_err;
   logic [CW-1:0] chk_err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: what the latch should show right now.
   logic [W-1:0] mdl;

   data_latch #(
      .WIDTH       (W),
      .RESET_VALUE ('0),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .in          (in),
      .out         (out),
      .chk_err     (chk_err),
      .chk_err_cnt (chk_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply inputs and advance the model: reset wins, then transparency, else hold.
   task automatic drive(input logic r, input logic e, input logic [W-1:0] d);
      rst_n  = r;
      enable = e;
      in     = d;
      if (!r)     mdl = '0;
      else if (e) mdl = d;
   endtask

   task automatic edge_mid();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [W-1:0] v;
      mdl = '0;

      // Reset holds out at RESET_VALUE despite enable=1.
      drive(1'b0, 1'b1, 2'b10);
      repeat (3) edge_mid();
      #1;
      chk("reset_out", 32'(out), 32'(2'b00));
      chk("reset_err", 32'(chk_err), 32'd0);
      chk("reset_cnt", 32'(chk_err_cnt), 32'd0);

      // Release with enable low: out keeps the reset value.
      drive(1'b1, 1'b0, 2'b10);
      for (int i = 0; i < 3; i++) begin
         edge_mid();
         chk("hold_after_reset", 32'(out), 32'(2'b00));
         chk("hold_after_reset_err", 32'(chk_err), 32'd0);
      end

      // Transparent sequence with wrap-around.
      @(posedge clk);
      drive(1'b1, 1'b1, 2'b10);
      #1;
      chk("transp_0", 32'(out), 32'(mdl));
      v = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         v = v + 2'b01;
         drive(1'b1, 1'b1, v);
         #0.1;
         chk("transp_follow", 32'(out), 32'(v));
      end
      #3;
      chk("transp_err", 32'(chk_err), 32'd0);

      // Hold: capture 01 then wiggle in.
      edge_mid();
      drive(1'b1, 1'b1, 2'b01);
      #1;
      drive(1'b1, 1'b0, 2'b01);
      #1;
      drive(1'b1, 1'b0, 2'b10);
      #1;
      chk("hold_10", 32'(out), 32'(2'b01));
      edge_mid();
      drive(1'b1, 1'b0, 2'b11);
      #1;
      chk("hold_11", 32'(out), 32'(2'b01));
      chk("hold_model", 32'(out), 32'(mdl));

      // Randomized stimulus against the model, including mid-cycle changes
      // and occasional reset pulses.
      for (int i = 0; i < 200; i++) begin
         logic r, e;
         logic [W-1:0] d;
         edge_mid();
         r = ($urandom_range(0, 19) != 0);
         e = 1'($urandom_range(0, 1));
         d = W'($urandom);
         drive(r, e, d);
         #1;
         chk("rand_out", 32'(out), 32'(mdl));
         chk("rand_err", 32'(chk_err), 32'd0);
         if ($urandom_range(0, 3) == 0) begin
            #2;
            drive(rst_n, enable, W'($urandom));
            #1;
            chk("rand_mid_out", 32'(out), 32'(mdl));
         end
      end

`ifdef DATA_LATCH_CHECKER_EN
      // Clean slate, then one forced mismatch while transparent.
      edge_mid();
      drive(1'b0, 1'b1, 2'b01);
      #1;
      drive(1'b1, 1'b1, 2'b01);
      edge_mid();
      force dut.out = 2'b10;
      edge_mid();
      release dut.out;
      chk("chk_err_set", 32'(chk_err), 32'd1);
      chk("chk_cnt_one", 32'(chk_err_cnt), 32'd1);
      edge_mid();
      chk("chk_err_sticky", 32'(chk_err), 32'd1);
      chk("chk_cnt_stays", 32'(chk_err_cnt), 32'd1);
      // Repeated violations saturate the counter.
      force dut.out = 2'b10;
      repeat (2 ** CW + 4) edge_mid();
      release dut.out;
      edge_mid();
      chk("chk_cnt_sat", 32'(chk_err_cnt), 32'((2 ** CW) - 1));
`endif

      // Reset during hold clears out and checker status asynchronously.
      edge_mid();
      drive(1'b1, 1'b1, 2'b11);
      #1;
      drive(1'b1, 1'b0, 2'b11);
      edge_mid();
      chk("pre_reset_hold", 32'(out), 32'(2'b11));
      drive(1'b0, 1'b0, 2'b11);
      #1;
      chk("async_reset_out", 32'(out), 32'(2'b00));
      chk("async_reset_err", 32'(chk_err), 32'd0);
      chk("async_reset_cnt", 32'(chk_err_cnt), 32'd0);
      #1;
      drive(1'b1, 1'b0, 2'b11);
      edge_mid();
      chk("post_reset_hold", 32'(out), 32'(2'b00));
      chk("post_reset_err", 32'(chk_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
